// File: rtl/sa_result_writer.sv
// Output end of the 3x3 systolic array: deskews column partial sums, requantizes them to int8
// and writes N_ROWS x 3 bytes row-major from out_baseaddr. Optional ReLU with `define SA_WB_RELU_EN.
module sa_wb_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          full, push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;
    assign ovf_o   = push_i && full;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module sa_result_writer #(
    parameter int ACC_W  = 20,
    parameter int N_ROWS = 3,
    parameter int DEPTH  = 4,
    parameter int SHIFT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Writer_en,
    input  logic [5:0]       out_baseaddr,
    input  logic [ACC_W-1:0] psum_1,
    input  logic [ACC_W-1:0] psum_2,
    input  logic [ACC_W-1:0] psum_3,
    input  logic             psum_valid_1,
    input  logic             psum_valid_2,
    input  logic             psum_valid_3,
    output logic             wr_en,
    output logic [5:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             is_WB_done_o,
    output logic             ovf_err_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(128);

    state_t     state_q;
    logic [5:0] addr_q;
    logic [3:0] row_cnt_q;
    logic [1:0] col_idx_q;
    logic       last_q;
    logic       wr_en_q, done_q, ovf_q;
    logic [5:0] wr_addr_q;
    logic [7:0] wr_data_q;

    logic [2:0][ACC_W-1:0] psum_v, dout_v;
    logic [2:0]            vld_v, empty_v, ovf_v;
    logic [ACC_W-1:0]      head;
    logic                  clr, ready, issue, pop;

    assign psum_v = {psum_3, psum_2, psum_1};
    assign vld_v  = {psum_valid_3, psum_valid_2, psum_valid_1};
    assign clr    = (state_q == IDLE) && Writer_en;
    assign ready  = ~|empty_v;
    assign issue  = (state_q == COLLECT) && !last_q && ready;
    assign pop    = issue && (col_idx_q == 2'd2);

    for (genvar k = 0; k < 3; k++) begin : g_col
        sa_wb_fifo #(.W(ACC_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clr),
            .push_i  ((state_q == COLLECT) && vld_v[k]),
            .pop_i   (pop),
            .din_i   (psum_v[k]),
            .dout_o  (dout_v[k]),
            .empty_o (empty_v[k]),
            .ovf_o   (ovf_v[k])
        );
    end

    always_comb begin
        head = dout_v[0];
        case (col_idx_q)
            2'd1:    head = dout_v[1];
            2'd2:    head = dout_v[2];
            default: head = dout_v[0];
        endcase
    end

    function automatic logic [7:0] requant(input logic [ACC_W-1:0] p);
        logic signed [ACC_W-1:0] t;
        t = $signed(p) >>> SHIFT;
`ifdef SA_WB_RELU_EN
        if (t < 0) t = '0;
`endif
        if (t > MAXV)      requant = 8'h7F;
        else if (t < MINV) requant = 8'h80;
        else               requant = t[7:0];
    endfunction

    // last_q delays DONE by one cycle so done rises after the final byte's write cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            row_cnt_q <= '0;
            col_idx_q <= '0;
            last_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (|ovf_v) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (Writer_en) begin
                    state_q   <= COLLECT;
                    addr_q    <= out_baseaddr;
                    row_cnt_q <= '0;
                    col_idx_q <= '0;
                    last_q    <= 1'b0;
                end
                COLLECT: begin
                    if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        last_q  <= 1'b0;
                    end else if (issue) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= requant(head);
                        addr_q    <= addr_q + 6'd1;
                        if (col_idx_q == 2'd2) begin
                            col_idx_q <= '0;
                            row_cnt_q <= row_cnt_q + 4'd1;
                            if (row_cnt_q == 4'(N_ROWS - 1)) last_q <= 1'b1;
                        end else begin
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end
                end
                DONE: if (!Writer_en) begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign is_WB_done_o = done_q;
    assign ovf_err_o    = ovf_q;
endmodule
